bus_mem_responder: RTL and testbench
====================================

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 12: word-address bits decoded inside the window (4096 x 16-bit words).
REQ-002 Parameter BASE_ADDR, default 16'h0000: window base; only bits [15:DEPTH_LOG2] are compared.
REQ-003 Parameter WAIT_STATES, default 1, range 0..15: extra cycles between request capture and response.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ADDRBUS  input  16  word address from the CPU.
REQ-007 CTRLBUS  input  2  command: 00 none, 01 read, 10 write, 11 reserved.
REQ-008 DATABUS  inout  16  shared data bus: CPU drives it for writes, this block drives it for reads only.
REQ-009 rdy  output  1  one-cycle response strobe.
REQ-010 err  output  1  one-cycle error strobe (see Configuration).

Function
REQ-011 Select when ADDRBUS[15:DEPTH_LOG2] == BASE_ADDR[15:DEPTH_LOG2]; offset = ADDRBUS[DEPTH_LOG2-1:0].
REQ-012 FSM states: IDLE, WAIT, RESP, DONE.
REQ-013 IDLE: selected CTRLBUS 01/10 at edge k -> latch offset, command and DATABUS (write data); go to WAIT with counter = WAIT_STATES, or to RESP when WAIT_STATES = 0.
REQ-014 WAIT: counter decrements each edge; the edge at which it reaches 0 enters RESP, i.e. RESP is entered at edge k+WAIT_STATES.
REQ-015 Read: the read-data register loads mem[offset] on the edge entering RESP; DATABUS carries it for exactly the RESP cycle and is high-Z in every other cycle.
REQ-016 Write: mem[offset] is written with the latched data on the edge entering RESP; DATABUS is never driven during a write.
REQ-017 rdy is registered, high for exactly the RESP cycle, 0 otherwise.
REQ-018 RESP -> DONE unconditionally; DONE -> IDLE only on an edge where CTRLBUS == 00, so a held request is served once.
REQ-019 CTRLBUS == 00 sampled in WAIT aborts: -> IDLE, no write, no rdy, no drive.
REQ-020 Changes of ADDRBUS/CTRLBUS/DATABUS after capture are ignored until DONE exits.
REQ-021 Unselected addresses: no state change, no drive, no strobes.

Reset
REQ-022 On reset low, immediately: state IDLE, counter 0, rdy 0, err 0, DATABUS high-Z, latched registers 0; memory contents are not cleared.
REQ-023 Reset asserted mid-operation cancels it; an uncommitted write is never performed.

Configuration
REQ-024 Macro BUS_MEM_ERR_EN defined: selected CTRLBUS 11 in IDLE -> err high for the next cycle, no memory access, then DONE (REQ-018 exit rule).
REQ-025 BUS_MEM_ERR_EN undefined: CTRLBUS 11 is ignored as 00; err is constant 0; port list is unchanged.

Structure
REQ-026 Package bus_mem_pkg holds the CTRL_NONE/CTRL_READ/CTRL_WRITE/CTRL_RSVD constants and the FSM state encoding; the CPU side uses the same constants.
REQ-027 One sub-module bus_mem_array: synchronous single-port 2^DEPTH_LOG2 x 16 RAM (we, addr, wdata, rdata registered); the tristate driver and FSM stay in bus_mem_responder.

Verification
REQ-028 WAIT_STATES=1: write 10/0x0010/0xBEEF at edge k -> rdy high only in the cycle after edge k+1, DATABUS high-Z throughout; CTRLBUS 00, then read 01/0x0010 -> DATABUS = 0xBEEF exactly in the rdy cycle.
REQ-029 WAIT_STATES=0: read 0x0000 after writing 0x1234 -> rdy in the cycle after the capture edge; CTRLBUS held at 01 for 6 cycles -> exactly one rdy pulse.
REQ-030 BASE_ADDR=16'h8000, DEPTH_LOG2=12: write to 0x7FFF and to 0x9000 -> no rdy, no drive; write to 0x8FFF -> rdy, and readback gives the written value.
REQ-031 WAIT_STATES=3: write 0x0020/0xAAAA, CTRLBUS -> 00 in the second WAIT cycle -> no rdy; later read of 0x0020 returns the previous contents.
REQ-032 Reset pulse low during WAIT of a write -> rdy 0, DATABUS high-Z immediately; target word unchanged; the next request completes normally.
REQ-033 With BUS_MEM_ERR_EN: CTRLBUS 11 at 0x0005 -> err high for one cycle, rdy 0, mem[5] unchanged; without it -> err stays 0, no response.

Source files
------------

// File: rtl/bus_mem_pkg.sv
// Shared bus command encoding and responder FSM state encoding.
// Both the CPU side and bus_mem_responder decode CTRLBUS with these constants.
package bus_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [1:0] CTRL_NONE  = 2'b00;
  localparam logic [1:0] CTRL_READ  = 2'b01;
  localparam logic [1:0] CTRL_WRITE = 2'b10;
  localparam logic [1:0] CTRL_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_access(input logic [1:0] ctrl);
    return (ctrl == CTRL_READ) || (ctrl == CTRL_WRITE);
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Synchronous single-port RAM, 2^DEPTH_LOG2 x 16, one-cycle registered read.
// No backpressure: a write or read is accepted on every rising edge.
module bus_mem_array
  import bus_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  // No reset on purpose: contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-mapped word responder: request captured in IDLE, rdy/read data WAIT_STATES cycles later.
// Held requests are served once (DONE waits for CTRLBUS idle); BUS_MEM_ERR_EN enables the err strobe.
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int                DEPTH_LOG2  = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int                WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ADDRBUS,
  input  logic [1:0]        CTRLBUS,
  inout  wire  [DATA_W-1:0] DATABUS,
  output logic              rdy,
  output logic              err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] off_q, off_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [DATA_W-1:0]     wdat_q, wdat_d;
  logic                  rdy_q, rdy_d;
  logic                  err_q, err_d;
  logic                  drv_q, drv_d;

  logic                  sel;
  logic [1:0]            ctrl_eff;
  logic [1:0]            cmd_cur;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  assign sel = (ADDRBUS[ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2]);

`ifdef BUS_MEM_ERR_EN
  assign ctrl_eff = CTRLBUS;
`else
  assign ctrl_eff = (CTRLBUS == CTRL_RSVD) ? CTRL_NONE : CTRLBUS;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    cmd_d   = cmd_q;
    wdat_d  = wdat_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel && is_access(ctrl_eff)) begin
          off_d  = ADDRBUS[DEPTH_LOG2-1:0];
          cmd_d  = ctrl_eff;
          wdat_d = DATABUS;
          if (WAIT_INIT == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else if (sel && (ctrl_eff == CTRL_RSVD)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        if (ctrl_eff == CTRL_NONE) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
          end
        end
      end
      RESP: state_d = DONE;
      DONE: begin
        if (ctrl_eff == CTRL_NONE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the zero-wait path reaches RESP on the capture edge, so the RAM sees the live bus.
  assign cmd_cur   = (state_q == IDLE) ? ctrl_eff : cmd_q;
  assign mem_addr  = (state_q == IDLE) ? ADDRBUS[DEPTH_LOG2-1:0] : off_q;
  assign mem_wdata = (state_q == IDLE) ? DATABUS : wdat_q;
  assign mem_we    = reset && (state_d == RESP) && (cmd_cur == CTRL_WRITE);
  assign rdy_d     = (state_d == RESP);
  assign drv_d     = (state_d == RESP) && (cmd_cur == CTRL_READ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      off_q   <= '0;
      cmd_q   <= CTRL_NONE;
      wdat_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      cmd_q   <= cmd_d;
      wdat_q  <= wdat_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      drv_q   <= drv_d;
    end
  end

  bus_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  assign DATABUS = drv_q ? mem_rdata : {DATA_W{1'bz}};
  assign rdy     = rdy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized bench for bus_mem_responder: three instances (1, 0 and 3 wait states, two bases)
// checked cycle by cycle against a transaction-level memory model.
module tb_bus_mem_responder;
  import bus_mem_pkg::*;

  localparam int          W_A = 1;
  localparam int          W_B = 0;
  localparam int          W_C = 3;
  localparam logic [15:0] B_A = 16'h0000;
  localparam logic [15:0] B_B = 16'h8000;
  localparam logic [15:0] B_C = 16'h0000;
  localparam logic [15:0] FLOAT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_r [3];
  logic [1:0]  ctrl_r [3];
  logic [15:0] dout_r [3];
  logic        doe_r  [3];
  wire  [15:0] db0, db1, db2;
  logic        rdy0, rdy1, rdy2, err0, err1, err2;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [15:0] mdl [int];

  assign db0 = doe_r[0] ? dout_r[0] : 16'hzzzz;
  assign db1 = doe_r[1] ? dout_r[1] : 16'hzzzz;
  assign db2 = doe_r[2] ? dout_r[2] : 16'hzzzz;
  pullup (db0);
  pullup (db1);
  pullup (db2);

  always #5 clk = ~clk;

  bus_mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(B_A), .WAIT_STATES(W_A)) u_a (
    .clk(clk), .reset(rst_n), .ADDRBUS(addr_r[0]), .CTRLBUS(ctrl_r[0]),
    .DATABUS(db0), .rdy(rdy0), .err(err0));
  bus_mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(B_B), .WAIT_STATES(W_B)) u_b (
    .clk(clk), .reset(rst_n), .ADDRBUS(addr_r[1]), .CTRLBUS(ctrl_r[1]),
    .DATABUS(db1), .rdy(rdy1), .err(err1));
  bus_mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(B_C), .WAIT_STATES(W_C)) u_c (
    .clk(clk), .reset(rst_n), .ADDRBUS(addr_r[2]), .CTRLBUS(ctrl_r[2]),
    .DATABUS(db2), .rdy(rdy2), .err(err2));

  function automatic int ws_of(input int i);
    case (i)
      0:       return W_A;
      1:       return W_B;
      default: return W_C;
    endcase
  endfunction

  function automatic logic [15:0] base_of(input int i);
    case (i)
      0:       return B_A;
      1:       return B_B;
      default: return B_C;
    endcase
  endfunction

  function automatic logic [15:0] bus_of(input int i);
    case (i)
      0:       return db0;
      1:       return db1;
      default: return db2;
    endcase
  endfunction

  function automatic logic rdy_of(input int i);
    case (i)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic err_of(input int i);
    case (i)
      0:       return err0;
      1:       return err1;
      default: return err2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // abort_c: WAIT cycle index (>=1) in which CTRLBUS is idle; rst_c: cycle after which reset pulses.
  task automatic run_txn(input int i, input logic [1:0] cmd, input logic [15:0] a,
                         input logic [15:0] wd, input int abort_c, input int rst_c);
    int          w = ws_of(i);
    logic [15:0] b = base_of(i);
    int          key = i * 65536 + int'(a[11:0]);
    bit          sel, act, aborted, killed, rdy_exp, err_exp;
    logic [15:0] exp_rd, bus_exp;
    sel     = (a[15:12] == b[15:12]);
    act     = sel && (cmd == CTRL_READ || cmd == CTRL_WRITE);
    aborted = act && abort_c >= 1 && abort_c < w;
    killed  = act && rst_c >= 0 && rst_c < w;
    exp_rd  = (cmd == CTRL_READ && mdl.exists(key)) ? mdl[key] : FLOAT;
    addr_r[i] = a;
    ctrl_r[i] = cmd;
    dout_r[i] = wd;
    doe_r[i]  = (cmd == CTRL_WRITE);
    for (int c = 0; c < 6 + w; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        doe_r[i] = 1'b0;
        if (act) begin
          addr_r[i] = 16'($urandom);
          dout_r[i] = 16'($urandom);
        end
      end
      @(negedge clk);
      rdy_exp = act && !aborted && (c == w);
      bus_exp = (rdy_exp && cmd == CTRL_READ) ? exp_rd : FLOAT;
`ifdef BUS_MEM_ERR_EN
      err_exp = sel && (cmd == CTRL_RSVD) && (c == 0);
`else
      err_exp = 1'b0;
`endif
      chk($sformatf("i%0d a%h rdy c%0d", i, a, c), 16'(rdy_of(i)), 16'(rdy_exp));
      chk($sformatf("i%0d a%h bus c%0d", i, a, c), bus_of(i), bus_exp);
      chk($sformatf("i%0d a%h err c%0d", i, a, c), 16'(err_of(i)), 16'(err_exp));
      if (c + 1 == abort_c) ctrl_r[i] = CTRL_NONE;
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1;
        chk($sformatf("i%0d rst rdy", i), 16'(rdy_of(i)), 16'd0);
        chk($sformatf("i%0d rst bus", i), bus_of(i), FLOAT);
        ctrl_r[i] = CTRL_NONE;
        @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
    end
    ctrl_r[i] = CTRL_NONE;
    doe_r[i]  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("i%0d a%h rdy tail", i, a), 16'(rdy_of(i)), 16'd0);
    if (act && !aborted && !killed && cmd == CTRL_WRITE) mdl[key] = wd;
  endtask

  initial begin
    int          r, ab;
    logic [15:0] a, b;
    for (int i = 0; i < 3; i++) begin
      addr_r[i] = '0;
      ctrl_r[i] = CTRL_NONE;
      dout_r[i] = '0;
      doe_r[i]  = 1'b0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d reset rdy", i), 16'(rdy_of(i)), 16'd0);
      chk($sformatf("i%0d reset err", i), 16'(err_of(i)), 16'd0);
      chk($sformatf("i%0d reset bus", i), bus_of(i), FLOAT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(0, CTRL_WRITE, 16'h0010, 16'hBEEF, 0, -1);
    run_txn(0, CTRL_READ,  16'h0010, 16'h0000, 0, -1);
    run_txn(0, CTRL_WRITE, 16'h1000, 16'h4444, 0, -1);

    run_txn(1, CTRL_WRITE, 16'h8000, 16'h1234, 0, -1);
    run_txn(1, CTRL_READ,  16'h8000, 16'h0000, 0, -1);
    run_txn(1, CTRL_WRITE, 16'h7FFF, 16'h1111, 0, -1);
    run_txn(1, CTRL_WRITE, 16'h9000, 16'h2222, 0, -1);
    run_txn(1, CTRL_WRITE, 16'h8FFF, 16'h5A5A, 0, -1);
    run_txn(1, CTRL_READ,  16'h8FFF, 16'h0000, 0, -1);
    run_txn(1, CTRL_READ,  16'h7FFF, 16'h0000, 0, -1);

    run_txn(2, CTRL_WRITE, 16'h0020, 16'h1111, 0, -1);
    run_txn(2, CTRL_WRITE, 16'h0020, 16'hAAAA, 1, -1);
    run_txn(2, CTRL_READ,  16'h0020, 16'h0000, 0, -1);
    run_txn(2, CTRL_WRITE, 16'h0020, 16'h2222, 0, 1);
    run_txn(2, CTRL_READ,  16'h0020, 16'h0000, 0, -1);
    run_txn(2, CTRL_WRITE, 16'h0021, 16'h3333, 0, -1);
    run_txn(2, CTRL_READ,  16'h0021, 16'h0000, 0, -1);

    run_txn(0, CTRL_READ,  16'h0010, 16'h0000, 0, 1);
    run_txn(0, CTRL_WRITE, 16'h0005, 16'h0505, 0, -1);
    run_txn(0, CTRL_RSVD,  16'h0005, 16'hDEAD, 0, -1);
    run_txn(0, CTRL_READ,  16'h0005, 16'h0000, 0, -1);

    for (int i = 0; i < 3; i++) begin
      b = base_of(i);
      for (int off = 0; off < 8; off++)
        run_txn(i, CTRL_WRITE, b | 16'(off), 16'($urandom_range(0, 16'hFFFE)), 0, -1);
      for (int n = 0; n < 40; n++) begin
        r  = $urandom_range(0, 9);
        a  = b | 16'($urandom_range(0, 7));
        ab = (i == 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        if (r <= 3)      run_txn(i, CTRL_READ, a, 16'h0000, ab, -1);
        else if (r <= 6) run_txn(i, CTRL_WRITE, a, 16'($urandom_range(0, 16'hFFFE)), ab, -1);
        else if (r == 7) run_txn(i, CTRL_NONE, a, 16'h0000, 0, -1);
        else if (r == 8) run_txn(i, CTRL_RSVD, a, 16'h0000, 0, -1);
        else             run_txn(i, ($urandom_range(0, 1) == 1) ? CTRL_READ : CTRL_WRITE,
                                 a ^ 16'h4000, 16'($urandom_range(0, 16'hFFFE)), 0, -1);
      end
      for (int off = 0; off < 8; off++)
        run_txn(i, CTRL_READ, b | 16'(off), 16'h0000, 0, -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
